// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access path: access-type encodings, funct3 opcodes,
// FSM state encoding and the read-only CSR address test.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_READ_ONLY = 2'b00,
        CSR_WRITE     = 2'b01,
        CSR_SET       = 2'b10,
        CSR_CLEAR     = 2'b11
    } csr_access_t;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } csr_state_t;

    // CSR addresses with [11:10]==2'b11 are architecturally read-only.
    function automatic logic csr_is_readonly(input logic [11:0] num);
        return (num[11:10] == 2'b11);
    endfunction

endpackage

// File: rtl/csr_access_unit_op_decode.sv
// Combinational decode of a SYSTEM/CSR instruction into access type, operand and illegal flag.
// Illegal-instruction detection is enabled by defining CSR_ILLEGAL_CHECK_EN.
module csr_op_decode
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rs1_field,
    input  logic [11:0]     i_csr_num,
    input  logic [XLEN-1:0] i_rs1_value,
    output logic [1:0]      o_access_type,
    output logic [XLEN-1:0] o_operand,
    output logic            o_illegal,
    output logic            o_no_writeback
);

    csr_access_t w_type;
    logic        w_illegal;

    // SET/CLEAR with a zero source field must not produce a write side effect.
    always_comb begin
        w_type = CSR_READ_ONLY;
        case (i_funct3[1:0])
            2'b01:   w_type = CSR_WRITE;
            2'b10:   w_type = (i_rs1_field != 5'd0) ? CSR_SET : CSR_READ_ONLY;
            2'b11:   w_type = (i_rs1_field != 5'd0) ? CSR_CLEAR : CSR_READ_ONLY;
            default: w_type = CSR_READ_ONLY;
        endcase
    end

`ifdef CSR_ILLEGAL_CHECK_EN
    assign w_illegal = (i_funct3[1:0] == 2'b00)
                     || ((w_type != CSR_READ_ONLY) && csr_is_readonly(i_csr_num));
`else
    logic w_unused_num;
    assign w_unused_num = ^i_csr_num;
    assign w_illegal    = 1'b0;
`endif

    assign o_access_type  = w_illegal ? CSR_READ_ONLY : w_type;
    assign o_illegal      = w_illegal;
    assign o_no_writeback = (i_funct3[1:0] == 2'b00);
    assign o_operand      = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_rs1_field} : i_rs1_value;

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR port: one request in, one single-cycle CSR access, one response out.
// Optional illegal-instruction checking is enabled with CSR_ILLEGAL_CHECK_EN.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_instr,
    input  logic [XLEN-1:0] req_rs1_value,
    output logic [11:0]     csr_number,
    output logic [1:0]      csr_access_type,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_rd,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_we,
    output logic            rsp_illegal
);

    csr_state_t      r_state;
    logic [4:0]      r_rd;
    logic [11:0]     r_num;
    logic [1:0]      r_type;
    logic [XLEN-1:0] r_wdata;
    logic            r_illegal;
    logic            r_no_wb;

    logic [4:0]      r_rsp_rd;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_we;
    logic            r_rsp_illegal;

    logic [1:0]      w_dec_type;
    logic [XLEN-1:0] w_dec_operand;
    logic            w_dec_illegal;
    logic            w_dec_no_wb;
    logic            w_accept;
    logic            w_unused_opcode;

    assign w_unused_opcode = ^req_instr[6:0];

    csr_op_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_funct3       (req_instr[14:12]),
        .i_rs1_field    (req_instr[19:15]),
        .i_csr_num      (req_instr[31:20]),
        .i_rs1_value    (req_rs1_value),
        .o_access_type  (w_dec_type),
        .o_operand      (w_dec_operand),
        .o_illegal      (w_dec_illegal),
        .o_no_writeback (w_dec_no_wb)
    );

    assign w_accept = req_valid && (r_state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rd          <= '0;
            r_num         <= '0;
            r_type        <= CSR_READ_ONLY;
            r_wdata       <= '0;
            r_illegal     <= 1'b0;
            r_no_wb       <= 1'b0;
            r_rsp_rd      <= '0;
            r_rsp_data    <= '0;
            r_rsp_we      <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rd      <= req_instr[11:7];
                        r_num     <= req_instr[31:20];
                        r_type    <= w_dec_type;
                        r_wdata   <= w_dec_operand;
                        r_illegal <= w_dec_illegal;
                        r_no_wb   <= w_dec_no_wb;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // csr_rdata still shows the pre-write value on the committing edge.
                    r_rsp_rd      <= r_rd;
                    r_rsp_data    <= r_illegal ? '0 : csr_rdata;
                    r_rsp_we      <= (r_rd != 5'd0) && !r_illegal && !r_no_wb;
                    r_rsp_illegal <= r_illegal;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // CSR write-side outputs are only live in ACCESS, so a reset or idle cycle can never write.
    assign csr_number      = (r_state == ACCESS) ? r_num   : 12'd0;
    assign csr_access_type = (r_state == ACCESS) ? r_type  : CSR_READ_ONLY;
    assign csr_wdata       = (r_state == ACCESS) ? r_wdata : '0;

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_rd      = r_rsp_rd;
    assign rsp_data    = r_rsp_data;
    assign rsp_we      = r_rsp_we;
    assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed testbench for csr_access_unit with a small CSR register file model (mtvec, mie, mhartid).
module tb_csr_access_unit;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = '0;
    logic [31:0] req_rs1_value = '0;
    logic [11:0] csr_number;
    logic [1:0]  csr_access_type;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_we;
    logic        rsp_illegal;

    int n_vec = 0;
    int n_err = 0;

    csr_access_unit #(.XLEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_instr       (req_instr),
        .req_rs1_value   (req_rs1_value),
        .csr_number      (csr_number),
        .csr_access_type (csr_access_type),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rd          (rsp_rd),
        .rsp_data        (rsp_data),
        .rsp_we          (rsp_we),
        .rsp_illegal     (rsp_illegal)
    );

    always #5 clk = ~clk;

    // CSR register file model: commits on the clock edge, reads combinationally.
    logic        model_clr = 1'b1;
    logic [31:0] m_mtvec, m_mie, m_mhartid;
    int          wr_count;

    function automatic logic [31:0] upd(input logic [31:0] old, input logic [1:0] t, input logic [31:0] d);
        case (t)
            2'b01:   return d;
            2'b10:   return old | d;
            2'b11:   return old & ~d;
            default: return old;
        endcase
    endfunction

    always @(posedge clk) begin
        if (model_clr) begin
            m_mtvec   <= '0;
            m_mie     <= '0;
            m_mhartid <= '0;
            wr_count  <= 0;
        end else if (csr_access_type != CSR_READ_ONLY) begin
            wr_count <= wr_count + 1;
            case (csr_number)
                12'h305: m_mtvec   <= upd(m_mtvec, csr_access_type, csr_wdata);
                12'h304: m_mie     <= upd(m_mie, csr_access_type, csr_wdata);
                12'hF14: m_mhartid <= upd(m_mhartid, csr_access_type, csr_wdata);
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_number)
            12'h305: csr_rdata = m_mtvec;
            12'h304: csr_rdata = m_mie;
            12'hF14: csr_rdata = m_mhartid;
            default: csr_rdata = '0;
        endcase
    end

    function automatic logic [31:0] mk(input logic [11:0] csr, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, 7'h73};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns one cycle later with the DUT in ACCESS.
    task automatic drive_to_access(input logic [31:0] instr, input logic [31:0] val);
        req_instr     = instr;
        req_rs1_value = val;
        req_valid     = 1'b1;
        step();
        req_valid     = 1'b0;
    endtask

    task automatic finish_rsp();
        $display("txn: rd=%0d data=%08h we=%0b illegal=%0b", rsp_rd, rsp_data, rsp_we, rsp_illegal);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        n_vec++; if (csr_access_type !== 2'b00) begin n_err++; $display("FAIL reset_type: got %0h want 0", csr_access_type); end
        n_vec++; if (csr_number !== 12'h0) begin n_err++; $display("FAIL reset_number: got %0h want 0", csr_number); end
        n_vec++; if (csr_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %0h want 0", csr_wdata); end
        n_vec++; if ({rsp_rd, rsp_data, rsp_we, rsp_illegal} !== 39'h0) begin n_err++; $display("FAIL reset_rsp_fields: got rd=%0d data=%0h we=%0b ill=%0b want all 0", rsp_rd, rsp_data, rsp_we, rsp_illegal); end
        step();
        step();
        reset     = 1'b0;
        model_clr = 1'b0;
        step();
    endtask

    task automatic test_csrrw();
        drive_to_access(mk(12'h305, 5'd1, F3_CSRRW, 5'd5), 32'h8000_0100);
        n_vec++; if (csr_access_type !== CSR_WRITE) begin n_err++; $display("FAIL rw_type: got %0h want 1", csr_access_type); end
        n_vec++; if (csr_wdata !== 32'h8000_0100) begin n_err++; $display("FAIL rw_wdata: got %08h want 80000100", csr_wdata); end
        n_vec++; if (csr_number !== 12'h305) begin n_err++; $display("FAIL rw_number: got %0h want 305", csr_number); end
        n_vec++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rw_access_hs: got ready=%0b valid=%0b want 0 0", req_ready, rsp_valid); end
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rw_rsp_valid: got %0b want 1", rsp_valid); end
        n_vec++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL rw_rsp_data: got %08h want 0", rsp_data); end
        n_vec++; if (rsp_rd !== 5'd5 || rsp_we !== 1'b1 || rsp_illegal !== 1'b0) begin n_err++; $display("FAIL rw_rsp_ctl: got rd=%0d we=%0b ill=%0b want 5 1 0", rsp_rd, rsp_we, rsp_illegal); end
        finish_rsp();
        n_vec++; if (m_mtvec !== 32'h8000_0100) begin n_err++; $display("FAIL rw_mtvec_after: got %08h want 80000100", m_mtvec); end
    endtask

    task automatic test_csrrs_x0();
        // CSRRW with rd=x0 still writes: preload mie.
        drive_to_access(mk(12'h304, 5'd2, F3_CSRRW, 5'd0), 32'h0000_0888);
        n_vec++; if (csr_access_type !== CSR_WRITE) begin n_err++; $display("FAIL rwx0_type: got %0h want 1", csr_access_type); end
        step();
        n_vec++; if (rsp_we !== 1'b0) begin n_err++; $display("FAIL rwx0_we: got %0b want 0", rsp_we); end
        finish_rsp();
        n_vec++; if (m_mie !== 32'h888) begin n_err++; $display("FAIL rwx0_mie: got %08h want 888", m_mie); end
        drive_to_access(mk(12'h304, 5'd0, F3_CSRRS, 5'd3), 32'hFFFF_FFFF);
        n_vec++; if (csr_access_type !== CSR_READ_ONLY) begin n_err++; $display("FAIL rs_type: got %0h want 0", csr_access_type); end
        step();
        n_vec++; if (rsp_data !== 32'h888) begin n_err++; $display("FAIL rs_rsp_data: got %08h want 888", rsp_data); end
        n_vec++; if (rsp_we !== 1'b1 || rsp_rd !== 5'd3) begin n_err++; $display("FAIL rs_rsp_ctl: got we=%0b rd=%0d want 1 3", rsp_we, rsp_rd); end
        finish_rsp();
        n_vec++; if (m_mie !== 32'h888) begin n_err++; $display("FAIL rs_mie_after: got %08h want 888", m_mie); end
    endtask

    task automatic test_csrrci();
        drive_to_access(mk(12'h304, 5'd8, F3_CSRRCI, 5'd0), 32'hFFFF_FFFF);
        n_vec++; if (csr_access_type !== CSR_CLEAR) begin n_err++; $display("FAIL rci_type: got %0h want 3", csr_access_type); end
        n_vec++; if (csr_wdata !== 32'h8) begin n_err++; $display("FAIL rci_wdata: got %08h want 8", csr_wdata); end
        step();
        n_vec++; if (rsp_data !== 32'h888 || rsp_we !== 1'b0) begin n_err++; $display("FAIL rci_rsp: got data=%08h we=%0b want 888 0", rsp_data, rsp_we); end
        finish_rsp();
        n_vec++; if (m_mie !== 32'h880) begin n_err++; $display("FAIL rci_mie_after: got %08h want 880", m_mie); end
    endtask

    task automatic test_back_to_back();
        drive_to_access(mk(12'h305, 5'd1, F3_CSRRW, 5'd7), 32'h0000_1234);
        step();
        req_instr     = mk(12'h305, 5'd0, F3_CSRRS, 5'd9);
        req_rs1_value = 32'h0;
        req_valid     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h8000_0100 || rsp_rd !== 5'd7 || rsp_we !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%08h rd=%0d we=%0b want 1 80000100 7 1", i, rsp_valid, rsp_data, rsp_rd, rsp_we); end
            n_vec++; if (req_ready !== 1'b0 || csr_access_type !== 2'b00) begin n_err++; $display("FAIL bp_no_accept[%0d]: got ready=%0b type=%0h want 0 0", i, req_ready, csr_access_type); end
            step();
        end
        finish_rsp();
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle_gap: got ready=%0b valid=%0b want 1 0", req_ready, rsp_valid); end
        step();
        req_valid = 1'b0;
        n_vec++; if (csr_number !== 12'h305 || csr_access_type !== 2'b00) begin n_err++; $display("FAIL bp_second_access: got num=%0h type=%0h want 305 0", csr_number, csr_access_type); end
        step();
        n_vec++; if (rsp_data !== 32'h1234 || rsp_rd !== 5'd9) begin n_err++; $display("FAIL bp_second_rsp: got data=%08h rd=%0d want 1234 9", rsp_data, rsp_rd); end
        finish_rsp();
    endtask

    task automatic test_reset_mid_access();
        int wc;
        drive_to_access(mk(12'h305, 5'd1, F3_CSRRW, 5'd4), 32'hDEAD_0000);
        n_vec++; if (csr_access_type !== CSR_WRITE) begin n_err++; $display("FAIL mid_pre_type: got %0h want 1", csr_access_type); end
        wc = wr_count;
        #1 reset = 1'b1;
        #1;
        n_vec++; if (csr_access_type !== 2'b00 || csr_number !== 12'h0 || csr_wdata !== 32'h0) begin n_err++; $display("FAIL mid_csr_outs: got type=%0h num=%0h wdata=%08h want 0 0 0", csr_access_type, csr_number, csr_wdata); end
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rd !== 5'd0 || rsp_data !== 32'h0) begin n_err++; $display("FAIL mid_hs_outs: got ready=%0b valid=%0b rd=%0d data=%08h want 1 0 0 0", req_ready, rsp_valid, rsp_rd, rsp_data); end
        step();
        n_vec++; if (m_mtvec !== 32'h1234 || wr_count !== wc) begin n_err++; $display("FAIL mid_no_write: got mtvec=%08h writes=%0d want 1234 %0d", m_mtvec, wr_count, wc); end
        step();
        reset = 1'b0;
        step();
        drive_to_access(mk(12'h305, 5'd0, F3_CSRRS, 5'd6), 32'h0);
        step();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234 || rsp_rd !== 5'd6 || rsp_we !== 1'b1) begin n_err++; $display("FAIL mid_next_req: got valid=%0b data=%08h rd=%0d we=%0b want 1 1234 6 1", rsp_valid, rsp_data, rsp_rd, rsp_we); end
        finish_rsp();
    endtask

    task automatic test_illegal();
        logic [1:0] exp_type;
        logic       exp_ill;
        logic       exp_we;
`ifdef CSR_ILLEGAL_CHECK_EN
        exp_type = CSR_READ_ONLY;
        exp_ill  = 1'b1;
        exp_we   = 1'b0;
`else
        exp_type = CSR_WRITE;
        exp_ill  = 1'b0;
        exp_we   = 1'b1;
`endif
        drive_to_access(mk(12'hF14, 5'd1, F3_CSRRW, 5'd2), 32'h55);
        n_vec++; if (csr_access_type !== exp_type) begin n_err++; $display("FAIL ro_type: got %0h want %0h", csr_access_type, exp_type); end
        step();
        n_vec++; if (rsp_illegal !== exp_ill || rsp_we !== exp_we || rsp_data !== 32'h0) begin n_err++; $display("FAIL ro_rsp: got ill=%0b we=%0b data=%08h want %0b %0b 0", rsp_illegal, rsp_we, rsp_data, exp_ill, exp_we); end
        finish_rsp();
        drive_to_access(mk(12'h305, 5'd3, 3'b000, 5'd8), 32'hFFFF_FFFF);
        n_vec++; if (csr_access_type !== 2'b00) begin n_err++; $display("FAIL f3zero_type: got %0h want 0", csr_access_type); end
        step();
        n_vec++; if (rsp_we !== 1'b0 || rsp_illegal !== (exp_type == CSR_READ_ONLY)) begin n_err++; $display("FAIL f3zero_rsp: got we=%0b ill=%0b want 0 %0b", rsp_we, rsp_illegal, exp_type == CSR_READ_ONLY); end
        finish_rsp();
        n_vec++; if (m_mtvec !== 32'h1234) begin n_err++; $display("FAIL f3zero_no_write: got %08h want 1234", m_mtvec); end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_csrrs_x0();
        test_csrrci();
        test_back_to_back();
        test_reset_mid_access();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
